// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave that turns 48-bit command/address/data frames into single-cycle
// register-bus reads and writes. All SPI pins are oversampled into the clk domain.
module spi_reg_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int RD_CMD_BIT  = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        reg_write,
  output logic        reg_read,
  input  logic [31:0] reg_rdata,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_e;

  localparam logic [5:0] LAST_BIT = 6'd48;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  // NOTE: the synchronisers are deliberately left out of reset so they keep tracking
  // the pins while rst_n is low; a reset chain would fake a cs edge on release.
  always_ff @(posedge clk) begin
    sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
    cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
    mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  state_e      state_q;
  logic [5:0]  bit_cnt_q;
  logic [31:0] shift_q;
  logic [31:0] miso_sr_q;
  logic        is_read_q;
  logic        rd_pend_q;
  logic        wr_pend_q;
  logic        spi_miso_q;
  logic [7:0]  reg_addr_q;
  logic [31:0] reg_wdata_q;
  logic        reg_write_q, reg_read_q, frame_done_q, frame_err_q;

  logic        in_frame, bit_take;
  logic [5:0]  bit_cnt_d;
  logic [31:0] shift_d;

  // The counter saturates at 48; later sclk edges in the same frame are dropped.
  assign in_frame  = (state_q != IDLE);
  assign bit_take  = in_frame & sclk_rise & (bit_cnt_q < LAST_BIT);
  assign bit_cnt_d = bit_take ? bit_cnt_q + 6'd1 : bit_cnt_q;
  assign shift_d   = {shift_q[30:0], mosi_s};

  // NOTE: every register here is state, so only non-blocking assignments are used;
  // later statements in the block deliberately override earlier defaults.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      miso_sr_q    <= '0;
      is_read_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      wr_pend_q    <= 1'b0;
      spi_miso_q   <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_write_q  <= 1'b0;
      reg_read_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      reg_read_q   <= 1'b0;
      wr_pend_q    <= 1'b0;
      reg_write_q  <= wr_pend_q;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      rd_pend_q    <= reg_read_q;

      // Register file answers one cycle after the read strobe.
      if (rd_pend_q && in_frame) miso_sr_q <= reg_rdata;

      if (bit_take) begin
        shift_q   <= shift_d;
        bit_cnt_q <= bit_cnt_d;
        case (bit_cnt_d)
          6'd8: begin
            is_read_q <= shift_d[RD_CMD_BIT];
            state_q   <= ADDR;
          end
          6'd16: begin
            reg_addr_q <= shift_d[7:0];
            reg_read_q <= is_read_q;
            state_q    <= DATA;
          end
          LAST_BIT: begin
            state_q <= DONE;
            if (!is_read_q) begin
              reg_wdata_q <= shift_d;
              wr_pend_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Falling edges 16..47 present rdata[31] down to rdata[0].
      if (in_frame && sclk_fall && is_read_q && bit_cnt_q >= 6'd16 && bit_cnt_q < LAST_BIT) begin
        spi_miso_q <= miso_sr_q[31];
        miso_sr_q  <= {miso_sr_q[30:0], 1'b0};
      end

      // A bit arriving with cs release is counted before the frame is judged.
      if (in_frame && cs_rise) begin
        state_q    <= IDLE;
        spi_miso_q <= 1'b0;
        if (bit_cnt_d == LAST_BIT) begin
          frame_done_q <= 1'b1;
        end else if (bit_cnt_d != 6'd0) begin
          frame_err_q <= 1'b1;
          miso_sr_q   <= '0;
          rd_pend_q   <= 1'b0;
        end
      end

      if (cs_fall) begin
        state_q    <= CMD;
        bit_cnt_q  <= '0;
        shift_q    <= '0;
        miso_sr_q  <= '0;
        is_read_q  <= 1'b0;
        rd_pend_q  <= 1'b0;
        spi_miso_q <= 1'b0;
      end
    end
  end

  assign busy        = in_frame;
  assign spi_miso_oe = in_frame;
  assign spi_miso    = spi_miso_q;
  assign reg_addr    = reg_addr_q;
  assign reg_wdata   = reg_wdata_q;
  assign reg_write   = reg_write_q;
  assign reg_read    = reg_read_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: an SPI host driver, a register-file model
// answering reads one cycle late, and pulse monitors on the register bus.
module tb_spi_reg_bridge;

  localparam int HALF = 4;  // sclk half period in clk cycles (8-clk minimum period)

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_sclk, spi_cs_n, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_write, reg_read;
  logic [31:0] reg_rdata = '0;
  logic        busy, frame_done, frame_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_reg_bridge #(.SYNC_STAGES(2), .RD_CMD_BIT(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_write(reg_write), .reg_read(reg_read), .reg_rdata(reg_rdata),
    .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
  );

  // Register file model: read data valid one clk after reg_read.
  logic [31:0] mem [256];
  always @(posedge clk) if (reg_read === 1'b1) reg_rdata <= mem[reg_addr];

  int n_wr = 0, n_rd = 0, n_done = 0, n_err = 0, n_both = 0;
  logic [7:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  always @(posedge clk) begin
    if (reg_write === 1'b1) begin n_wr++; wr_addr = reg_addr; wr_data = reg_wdata; end
    if (reg_read === 1'b1) begin n_rd++; rd_addr = reg_addr; end
    if (frame_done === 1'b1) n_done++;
    if (frame_err === 1'b1) n_err++;
    if (reg_write === 1'b1 && reg_read === 1'b1) n_both++;
  end

  int s_wr, s_rd, s_done, s_err;
  task automatic snap();
    s_wr = n_wr; s_rd = n_rd; s_done = n_done; s_err = n_err;
  endtask

  task automatic sclk_bit(input logic b, output logic miso_s);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    miso_s   = spi_miso;
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  task automatic close_cs();
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  // Sends bits[63] first; miso_v[47-i] holds MISO sampled at rising edge i+1.
  task automatic frame(input logic [63:0] bits, input int n, input bit close,
                       output logic [47:0] miso_v);
    logic m;
    spi_cs_n = 1'b0;
    miso_v   = '0;
    for (int i = 0; i < n; i++) begin
      sclk_bit(bits[63-i], m);
      if (i < 48) miso_v[47-i] = m;
    end
    if (close) close_cs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({busy, spi_miso_oe, spi_miso} !== 3'b000) begin
      failures++; $display("FAIL reset_status: got %b expected 000", {busy, spi_miso_oe, spi_miso});
    end
    checks++;
    if ({reg_write, reg_read, frame_done, frame_err} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes: got %b expected 0000", {reg_write, reg_read, frame_done, frame_err});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({reg_addr, reg_wdata} !== 40'h0) begin
      failures++; $display("FAIL reset_bus: got %h expected 0", {reg_addr, reg_wdata});
    end
  endtask

  task automatic test_write();
    logic [47:0] mv;
    snap();
    frame({8'h00, 8'h0E, 32'h0000_0064, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h0E || wr_data !== 32'h64) begin
      failures++; $display("FAIL write_basic: got n=%0d a=%h d=%h expected n=1 a=0e d=00000064", n_wr - s_wr, wr_addr, wr_data);
    end
    checks++;
    if (n_done - s_done !== 1 || n_rd - s_rd !== 0 || n_err - s_err !== 0) begin
      failures++; $display("FAIL write_flags: got done=%0d rd=%0d err=%0d expected 1 0 0", n_done - s_done, n_rd - s_rd, n_err - s_err);
    end
  endtask

  task automatic test_read();
    logic [47:0] mv;
    mem[8'h17] = 32'h5631_3030;
    snap();
    frame({8'h80, 8'h17, 32'h0, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (n_rd - s_rd !== 1 || rd_addr !== 8'h17) begin
      failures++; $display("FAIL read_strobe: got n=%0d a=%h expected n=1 a=17", n_rd - s_rd, rd_addr);
    end
    checks++;
    if (mv[31:0] !== 32'h5631_3030) begin
      failures++; $display("FAIL read_miso_data: got %h expected 56313030", mv[31:0]);
    end
    checks++;
    if (mv[47:32] !== 16'h0) begin
      failures++; $display("FAIL read_miso_hdr: got %h expected 0000", mv[47:32]);
    end
    checks++;
    if (n_wr - s_wr !== 0 || n_done - s_done !== 1) begin
      failures++; $display("FAIL read_flags: got wr=%0d done=%0d expected 0 1", n_wr - s_wr, n_done - s_done);
    end
  endtask

  task automatic test_abort();
    logic [47:0] mv;
    snap();
    frame({8'h00, 8'h22, 32'hCAFE_F00D, 16'h0}, 30, 1'b0, mv);
    checks++;
    if ({busy, spi_miso_oe} !== 2'b11) begin
      failures++; $display("FAIL abort_busy: got %b expected 11", {busy, spi_miso_oe});
    end
    close_cs();
    checks++;
    if (n_err - s_err !== 1 || n_wr - s_wr !== 0 || n_done - s_done !== 0) begin
      failures++; $display("FAIL abort_flags: got err=%0d wr=%0d done=%0d expected 1 0 0", n_err - s_err, n_wr - s_wr, n_done - s_done);
    end
    snap();
    frame({8'h00, 8'h18, 32'h0000_001F, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h18 || wr_data !== 32'h1F || n_err - s_err !== 0) begin
      failures++; $display("FAIL abort_recover: got n=%0d a=%h d=%h expected n=1 a=18 d=0000001f", n_wr - s_wr, wr_addr, wr_data);
    end
  endtask

  task automatic test_overrun();
    logic [47:0] mv;
    snap();
    frame({8'h00, 8'h31, 32'h1234_5678, 8'hFF, 8'hA5}, 56, 1'b1, mv);
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h31 || wr_data !== 32'h1234_5678) begin
      failures++; $display("FAIL overrun_write: got n=%0d a=%h d=%h expected n=1 a=31 d=12345678", n_wr - s_wr, wr_addr, wr_data);
    end
    checks++;
    if (n_done - s_done !== 1 || n_err - s_err !== 0) begin
      failures++; $display("FAIL overrun_flags: got done=%0d err=%0d expected 1 0", n_done - s_done, n_err - s_err);
    end
  endtask

  // Bit 48's rising sclk edge and the cs release land on the same clk edge.
  task automatic test_simultaneous();
    logic [63:0] bits;
    logic        m;
    bits = {8'h00, 8'h09, 32'h0F0F_A5A5, 16'h0};
    snap();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 47; i++) sclk_bit(bits[63-i], m);
    spi_mosi = bits[16];
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b1;
    spi_cs_n = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
    repeat (4 * HALF) @(negedge clk);
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h09 || wr_data !== 32'h0F0F_A5A5) begin
      failures++; $display("FAIL simul_write: got n=%0d a=%h d=%h expected n=1 a=09 d=0f0fa5a5", n_wr - s_wr, wr_addr, wr_data);
    end
    checks++;
    if (n_done - s_done !== 1 || n_err - s_err !== 0) begin
      failures++; $display("FAIL simul_flags: got done=%0d err=%0d expected 1 0", n_done - s_done, n_err - s_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [63:0] bits;
    logic [47:0] mv;
    logic        m;
    bits = {8'h00, 8'h3C, 32'h1111_2222, 16'h0};
    snap();
    spi_cs_n = 1'b0;
    for (int i = 0; i < 20; i++) sclk_bit(bits[63-i], m);
    rst_n = 1'b0;
    for (int i = 20; i < 24; i++) sclk_bit(bits[63-i], m);
    rst_n = 1'b1;
    for (int i = 24; i < 30; i++) sclk_bit(bits[63-i], m);
    checks++;
    if ({busy, spi_miso_oe, spi_miso} !== 3'b000 || reg_addr !== 8'h00 || reg_wdata !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs: got st=%b a=%h d=%h expected 000 00 00000000", {busy, spi_miso_oe, spi_miso}, reg_addr, reg_wdata);
    end
    for (int i = 30; i < 48; i++) sclk_bit(bits[63-i], m);
    close_cs();
    checks++;
    if (n_wr - s_wr !== 0 || n_rd - s_rd !== 0 || n_done - s_done !== 0 || n_err - s_err !== 0) begin
      failures++; $display("FAIL rstmid_strobes: got wr=%0d rd=%0d done=%0d err=%0d expected 0 0 0 0", n_wr - s_wr, n_rd - s_rd, n_done - s_done, n_err - s_err);
    end
    snap();
    frame({8'h00, 8'h0A, 32'h00C0_FFEE, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h0A || wr_data !== 32'h00C0_FFEE || n_done - s_done !== 1) begin
      failures++; $display("FAIL rstmid_recover: got n=%0d a=%h d=%h expected n=1 a=0a d=00c0ffee", n_wr - s_wr, wr_addr, wr_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [47:0] mv;
    mem[8'h2A] = 32'hA5C3_0F96;
    snap();
    frame({8'h80, 8'h2A, 32'h0, 16'h0}, 48, 1'b1, mv);
    frame({8'h00, 8'h05, 32'hDEAD_BEEF, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (n_rd - s_rd !== 1 || rd_addr !== 8'h2A) begin
      failures++; $display("FAIL b2b_read: got n=%0d a=%h expected n=1 a=2a", n_rd - s_rd, rd_addr);
    end
    checks++;
    if (n_wr - s_wr !== 1 || wr_addr !== 8'h05 || wr_data !== 32'hDEAD_BEEF || n_done - s_done !== 2) begin
      failures++; $display("FAIL b2b_write: got n=%0d a=%h d=%h done=%0d expected n=1 a=05 d=deadbeef done=2", n_wr - s_wr, wr_addr, wr_data, n_done - s_done);
    end
  endtask

  task automatic test_b2b_miso();
    logic [47:0] mv;
    mem[8'h2B] = 32'h8000_0001;
    frame({8'h80, 8'h2B, 32'h0, 16'h0}, 48, 1'b1, mv);
    checks++;
    if (mv !== {16'h0, 32'h8000_0001}) begin
      failures++; $display("FAIL b2b_miso: got %h expected 000080000001", mv);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_overrun();
    test_simultaneous();
    test_reset_mid_frame();
    test_back_to_back();
    test_b2b_miso();
    checks++;
    if (n_both !== 0) begin
      failures++; $display("FAIL strobe_overlap: got %0d expected 0", n_both);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- SPI slave that converts host serial transactions into the single-cycle register bus (addr/wdata/write/read/rdata) consumed by the 64-entry control register file.
- Sits between the board-level SPI pins and the register file. All SPI inputs are oversampled and synchronised into clk; there is no SPI-clock domain logic.
- Supports single-register write and read frames of 48 bits, with abort detection and frame-error reporting.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers on spi_sclk, spi_cs_n and spi_mosi (legal range 2..3).
- RD_CMD_BIT, 7, bit index within the command byte that selects read (1) or write (0).

Ports:
- clk  in  1  system clock; spi_sclk period must be >= 8 clk periods.
- rst_n  in  1  reset, synchronous, active-low.
- spi_sclk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_cs_n  in  1  SPI chip select, active-low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  MISO tristate enable, high while the frame is selected.
- reg_addr  out  8  register address to the register file.
- reg_wdata  out  32  register write data.
- reg_write  out  1  one-cycle write strobe.
- reg_read  out  1  one-cycle read strobe.
- reg_rdata  in  32  read data, valid exactly 1 clk after reg_read.
- busy  out  1  high while a frame is in progress (cs active).
- frame_done  out  1  one-cycle pulse when a complete 48-bit frame ends.
- frame_err  out  1  one-cycle pulse when a frame is aborted before 48 bits.

Behaviour:
- Synchronisation: each SPI input passes through SYNC_STAGES flip-flops. Edges of spi_sclk and spi_cs_n are detected from the synchronised value versus its previous value.
- Frame format, MSB first:
  - bits 0-7: command byte; bit RD_CMD_BIT = 1 means read, all other command bits are ignored.
  - bits 8-15: address.
  - bits 16-47: data (MOSI for writes, MISO for reads).
- Bit counter:
  - 6 bits, increments on each synchronised sclk rising edge while cs is active.
  - Saturates at 48; any further edges are ignored and cause no bus activity.
- FSM states: IDLE, CMD, ADDR, DATA, DONE.
  - IDLE -> CMD on cs falling edge; counter and shift registers cleared.
  - CMD -> ADDR after bit 8 (command latched).
  - ADDR -> DATA after bit 16 (address latched to reg_addr).
  - DATA -> DONE after bit 48.
  - Any state -> IDLE on cs rising edge.
- Read path:
  - reg_read pulses for 1 cycle in the cycle the 16th rising edge is detected, with reg_addr already valid.
  - reg_rdata is captured into the 32-bit MISO shift register 1 cycle after reg_read.
  - spi_miso shifts on each detected sclk falling edge from falling edge 16 onward. MSB rdata[31] is presented after falling edge 16; rdata[0] is presented after falling edge 47.
  - Bits 0-15 of a read frame drive MISO 0.
- Write path: after bit 48, reg_wdata holds the 32 MOSI data bits and reg_write pulses 1 cycle in the cycle after the 48th edge is detected. No reg_write is issued for read frames.
- Strobes: reg_read and reg_write are never both high, and each fires at most once per frame.
- Outputs:
  - spi_miso_oe = busy = cs active (synchronised).
  - spi_miso = 0 whenever not selected.
- End of frame (cs rising edge):
  - Counter == 48: frame_done pulses.
  - Counter 1..47: frame_err pulses, no reg_write is issued, and any pending read data is discarded.
  - Counter == 0: neither pulse.
- Simultaneous events:
  - An sclk rising edge and a cs rising edge detected in the same cycle: the bit is counted first, then the frame closes. If that bit is bit 48, reg_write and frame_done both occur (reg_write 1 cycle later, as normal).
  - A cs falling edge while in DONE is treated as a new frame.
- Reset values: reg_addr 0, reg_wdata 0, reg_write 0, reg_read 0, spi_miso 0, spi_miso_oe 0, busy 0, frame_done 0, frame_err 0; FSM in IDLE, counter 0.
- Reset mid-frame: everything returns to reset values, with no strobe. The frame continuing on the pins is ignored until the next cs falling edge.

Test Plan:
- Write frame cmd 0x00, addr 0x0E, data 0x00000064 -> exactly one reg_write with reg_addr 0x0E and reg_wdata 0x00000064; frame_done pulses once; reg_read never asserts.
- Read frame cmd 0x80, addr 0x17, register model returns 0x56313030 -> one reg_read with reg_addr 0x17; MISO bits 16-47 sampled on sclk rising edges equal 0x56313030; no reg_write.
- Abort write after 30 bits (cs high) -> frame_err pulses once; no reg_write; next full write frame to 0x18 data 0x0000001F succeeds.
- 56 sclk edges in one write frame -> single reg_write after bit 48; bits 49-56 ignored; frame_done once.
- rst_n low at bit 20 of a write, then released mid-frame -> no strobes; all outputs at reset values; the following complete frame works.
- sclk at the minimum legal period (8 clk) with back-to-back read then write frames (cs high 2 sclk periods) -> correct rdata on MISO and correct write, with no dropped bits.
